vga_timing_gen: RTL

Parametrised, runtime-reconfigurable VGA timing generator for the display pipeline. It produces horizontal/vertical sync, display-enable and pixel/line coordinates from programmable porch/sync/display counts, advancing one pixel per pixel-clock enable. New timings are loaded through a valid/ready shadow register and take effect only at a frame boundary. The pixel source downstream consumes `x`, `y` and `de`; the DAC/pad stage consumes `h_sync` and `v_sync`.

---
 rtl/vga_timing_gen.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA timing generator: programmable porch/sync/display counts, one pixel per pix_en, with new
// timing held in a shadow register until the frame boundary. Define VGA_TIMING_LINE_IRQ_EN for line_cmp/line_irq.
module vga_timing_gen #(
    parameter int H_W    = 12,
    parameter int V_W    = 11,
    parameter int H_DISP = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_DISP = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter bit H_POL  = 1'b0,
    parameter bit V_POL  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pix_en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [4*H_W-1:0] cfg_h,
    input  logic [4*V_W-1:0] cfg_v,
    input  logic [1:0]       cfg_pol,
    output logic             cfg_err,
    output logic [H_W-1:0]   x,
    output logic [V_W-1:0]   y,
    output logic             de,
    output logic             h_sync,
    output logic             v_sync,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TIMING_LINE_IRQ_EN
    ,
    input  logic [V_W-1:0]   line_cmp,
    output logic             line_irq
`endif
);

    typedef struct packed {
        logic [H_W-1:0] h_disp;
        logic [H_W-1:0] h_fp;
        logic [H_W-1:0] h_sync;
        logic [H_W-1:0] h_bp;
        logic [V_W-1:0] v_disp;
        logic [V_W-1:0] v_fp;
        logic [V_W-1:0] v_sync;
        logic [V_W-1:0] v_bp;
        logic           h_pol;
        logic           v_pol;
    } timing_t;

    typedef enum logic {
        SHADOW_EMPTY,
        SHADOW_FULL
    } shadow_state_t;

    localparam logic [H_W-1:0] P_H_DISP = H_W'(H_DISP);
    localparam logic [H_W-1:0] P_H_FP   = H_W'(H_FP);
    localparam logic [H_W-1:0] P_H_SYNC = H_W'(H_SYNC);
    localparam logic [H_W-1:0] P_H_BP   = H_W'(H_BP);
    localparam logic [V_W-1:0] P_V_DISP = V_W'(V_DISP);
    localparam logic [V_W-1:0] P_V_FP   = V_W'(V_FP);
    localparam logic [V_W-1:0] P_V_SYNC = V_W'(V_SYNC);
    localparam logic [V_W-1:0] P_V_BP   = V_W'(V_BP);
    localparam logic [H_W-1:0] P_H_TOT  = P_H_DISP + P_H_FP + P_H_SYNC + P_H_BP;
    localparam logic [V_W-1:0] P_V_TOT  = P_V_DISP + P_V_FP + P_V_SYNC + P_V_BP;

    localparam timing_t RESET_TIMING = '{
        h_disp: P_H_DISP, h_fp: P_H_FP, h_sync: P_H_SYNC, h_bp: P_H_BP,
        v_disp: P_V_DISP, v_fp: P_V_FP, v_sync: P_V_SYNC, v_bp: P_V_BP,
        h_pol: H_POL, v_pol: V_POL
    };

    timing_t        active;
    timing_t        shadow;
    timing_t        cfg_in;
    timing_t        next_timing;
    shadow_state_t  state;
    shadow_state_t  state_next;

    logic [H_W-1:0] h_tot;
    logic [V_W-1:0] v_tot;
    logic [H_W-1:0] x_next;
    logic [V_W-1:0] y_next;
    logic [H_W-1:0] hs_start;
    logic [H_W-1:0] hs_end;
    logic [V_W-1:0] vs_start;
    logic [V_W-1:0] vs_end;
    logic           h_end;
    logic           v_end;
    logic           cfg_fire;
    logic           cfg_bad;
    logic           load_shadow;
    logic           apply_shadow;
    logic           de_next;
    logic           h_sync_next;
    logic           v_sync_next;

    always_comb begin
        cfg_in.h_disp = cfg_h[4*H_W-1 -: H_W];
        cfg_in.h_fp   = cfg_h[3*H_W-1 -: H_W];
        cfg_in.h_sync = cfg_h[2*H_W-1 -: H_W];
        cfg_in.h_bp   = cfg_h[H_W-1:0];
        cfg_in.v_disp = cfg_v[4*V_W-1 -: V_W];
        cfg_in.v_fp   = cfg_v[3*V_W-1 -: V_W];
        cfg_in.v_sync = cfg_v[2*V_W-1 -: V_W];
        cfg_in.v_bp   = cfg_v[V_W-1:0];
        cfg_in.h_pol  = cfg_pol[1];
        cfg_in.v_pol  = cfg_pol[0];
    end

    assign cfg_ready   = (state == SHADOW_EMPTY);
    assign cfg_fire    = cfg_valid && cfg_ready;
    assign cfg_bad     = (cfg_in.h_disp == '0) || (cfg_in.h_sync == '0) ||
                         (cfg_in.v_disp == '0) || (cfg_in.v_sync == '0);
    assign load_shadow = cfg_fire && !cfg_bad;

    assign h_tot = active.h_disp + active.h_fp + active.h_sync + active.h_bp;
    assign v_tot = active.v_disp + active.v_fp + active.v_sync + active.v_bp;
    assign h_end = (x == h_tot - H_W'(1));
    assign v_end = (y == v_tot - V_W'(1));

    // The shadow only lands on the last pixel of a frame, so the new timing starts cleanly at (0,0).
    assign apply_shadow = pix_en && h_end && v_end && (state == SHADOW_FULL);
    assign next_timing  = apply_shadow ? shadow : active;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SHADOW_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SHADOW_EMPTY: if (load_shadow)  state_next = SHADOW_FULL;
            SHADOW_FULL:  if (apply_shadow) state_next = SHADOW_EMPTY;
            default:      state_next = SHADOW_EMPTY;
        endcase
    end

    always_comb begin
        x_next = x + H_W'(1);
        y_next = y;
        if (h_end) begin
            x_next = '0;
            y_next = v_end ? '0 : y + V_W'(1);
        end
    end

    // Flags are derived from the coordinates about to be registered so they never skew from x/y.
    always_comb begin
        hs_start    = next_timing.h_disp + next_timing.h_fp;
        hs_end      = hs_start + next_timing.h_sync;
        vs_start    = next_timing.v_disp + next_timing.v_fp;
        vs_end      = vs_start + next_timing.v_sync;
        de_next     = (x_next < next_timing.h_disp) && (y_next < next_timing.v_disp);
        h_sync_next = ((x_next >= hs_start) && (x_next < hs_end)) ~^ next_timing.h_pol;
        v_sync_next = ((y_next >= vs_start) && (y_next < vs_end)) ~^ next_timing.v_pol;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x           <= P_H_TOT - H_W'(1);
            y           <= P_V_TOT - V_W'(1);
            de          <= 1'b0;
            h_sync      <= ~H_POL;
            v_sync      <= ~V_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            x           <= x_next;
            y           <= y_next;
            de          <= de_next;
            h_sync      <= h_sync_next;
            v_sync      <= v_sync_next;
            line_start  <= (x_next == '0);
            frame_start <= (x_next == '0) && (y_next == '0);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active  <= RESET_TIMING;
            shadow  <= '0;
            cfg_err <= 1'b0;
        end else begin
            if (apply_shadow) begin
                active <= shadow;
            end
            if (load_shadow) begin
                shadow <= cfg_in;
            end
            cfg_err <= cfg_fire && cfg_bad;
        end
    end

`ifdef VGA_TIMING_LINE_IRQ_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            line_irq <= 1'b0;
        end else begin
            line_irq <= pix_en && (x_next == '0) && (y_next == line_cmp);
        end
    end
`endif

endmodule
